// File: rtl/cordic_pkg.sv
// Shared Q2.30 types, constants and FSM encoding for the sequential CORDIC rotator.
package cordic_pkg;

    localparam int Q_WIDTH    = 32;
    localparam int ATAN_DEPTH = 8;

    typedef logic signed [Q_WIDTH-1:0] fixedT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam fixedT HALF_PI = 32'sh6487_ED51;

    // atan(2^-i) in Q2.30
    localparam fixedT ATAN [0:ATAN_DEPTH-1] = '{
        32'sh3243_F6A8, 32'sh1DAC_6705, 32'sh0FAD_BAFC, 32'sh07F5_6EA6,
        32'sh03FE_AB76, 32'sh01FF_D55B, 32'sh00FF_FAAA, 32'sh007F_FF55
    };

    // Elaboration-time gain correction: prod 1/sqrt(1+2^-2i), rounded to Q2.30.
    function automatic fixedT gainK(input int nIter);
        real k;
        real p;
        k = 1.0;
        p = 1.0;
        for (int j = 0; j < nIter; j++) begin
            k = k / $sqrt(1.0 + p);
            p = p / 4.0;
        end
        return fixedT'($rtoi(k * 1073741824.0 + 0.5));
    endfunction

endpackage

// File: rtl/cordic_iter_unit.sv
// One combinational CORDIC micro-rotation in rotation mode; direction follows the sign of z.
module cordic_iter_unit
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] z,
    input  logic        [2:0]       i,
    output logic signed [WIDTH-1:0] xNext,
    output logic signed [WIDTH-1:0] yNext,
    output logic signed [WIDTH-1:0] zNext
);

    logic signed [WIDTH-1:0] xShift;
    logic signed [WIDTH-1:0] yShift;
    logic signed [WIDTH-1:0] angle;

    assign xShift = x >>> i;
    assign yShift = y >>> i;
    assign angle  = ATAN[i];

    always_comb begin
        if (z[WIDTH-1]) begin
            xNext = x + yShift;
            yNext = y - xShift;
            zNext = z + angle;
        end else begin
            xNext = x - yShift;
            yNext = y + xShift;
            zNext = z - angle;
        end
    end

endmodule

// File: rtl/cordic_seq.sv
// Sequential CORDIC sine/cosine: one micro-rotation per clock, start/ready/done handshake.
module cordic_seq
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int N_ITER = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rad,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] cos_o,
    output logic [WIDTH-1:0] sin_o,
    output logic             err
);

    localparam fixedT      K_N       = gainK(N_ITER);
    localparam logic [2:0] LAST_ITER = 3'(N_ITER - 1);

    // Handshake: a request is taken on an edge where start=1 and ready=1;
    // ready is high only in IDLE, and done pulses for exactly one cycle with results valid.
    stateT                   state;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
    logic        [2:0]       i;
    logic signed [WIDTH-1:0] xNext;
    logic signed [WIDTH-1:0] yNext;
    logic signed [WIDTH-1:0] zNext;
    logic signed [WIDTH-1:0] radS;
    logic                    inRange;

    assign radS    = rad;
    assign inRange = (radS >= -HALF_PI) && (radS <= HALF_PI);

    cordic_iter_unit #(.WIDTH(WIDTH)) iterUnit (
        .x     (x),
        .y     (y),
        .z     (z),
        .i     (i),
        .xNext (xNext),
        .yNext (yNext),
        .zNext (zNext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            cos_o <= '0;
            sin_o <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            i     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (inRange) begin
                            x     <= K_N;
                            y     <= '0;
                            z     <= radS;
                            i     <= '0;
                            err   <= 1'b0;
                            state <= ITER;
                        end else begin
                            // Out-of-range angles skip the rotation and report immediately
                            cos_o <= '0;
                            sin_o <= '0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                ITER: begin
                    x <= xNext;
                    y <= yNext;
                    z <= zNext;
                    i <= i + 3'd1;
                    if (i == LAST_ITER) begin
                        cos_o <= xNext;
                        sin_o <= yNext;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_seq.sv
// Self-checking bench for cordic_seq: behavioural timing/result model plus directed vectors.
module tb_cordic_seq;

    localparam int          WIDTH  = 32;
    localparam int          N_ITER = 8;
    localparam logic [31:0] TOL    = 32'h0080_0000;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] rad   = '0;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] cos_o;
    logic [31:0] sin_o;

    always #5 clk = ~clk;

    cordic_seq #(.WIDTH(WIDTH), .N_ITER(N_ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .rad   (rad),
        .ready (ready),
        .done  (done),
        .cos_o (cos_o),
        .sin_o (sin_o),
        .err   (err)
    );

    int tests     = 0;
    int fails     = 0;
    int doneCount = 0;
    int cyc       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expV);
        tests++;
        if (act !== expV) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expV, $time);
        end
    endtask

    task automatic near(input string name, input logic [31:0] act, input logic [31:0] refV,
                        input logic [31:0] tol);
        longint d;
        tests++;
        d = longint'($signed(act)) - longint'($signed(refV));
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h +/- 0x%08h", name, act, refV, tol);
        end
    endtask

    // ---------------- behavioural model ----------------
    int atanTab [0:7] = '{32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
                          32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55};

    function automatic int gainRef();
        real k;
        real p;
        k = 1.0;
        p = 1.0;
        for (int j = 0; j < N_ITER; j++) begin
            k = k / $sqrt(1.0 + p);
            p = p / 4.0;
        end
        return $rtoi(k * 1073741824.0 + 0.5);
    endfunction

    task automatic rotate(input logic [31:0] r, output logic [31:0] c, output logic [31:0] s,
                          output logic e);
        int px, py, pz, sx, sy, hp;
        hp = 32'h6487ED51;
        if ($signed(r) > hp || $signed(r) < -hp) begin
            c = '0;
            s = '0;
            e = 1'b1;
        end else begin
            px = gainRef();
            py = 0;
            pz = r;
            for (int k = 0; k < N_ITER; k++) begin
                sx = px >>> k;
                sy = py >>> k;
                if (pz >= 0) begin
                    px = px - sy; py = py + sx; pz = pz - atanTab[k];
                end else begin
                    px = px + sy; py = py - sx; pz = pz + atanTab[k];
                end
            end
            c = px;
            s = py;
            e = 1'b0;
        end
    endtask

    // rem = cycles left before the block is ready again; done is expected when rem==1
    int          rem     = 0;
    bit          modelOn = 1'b0;
    logic [31:0] expCos  = '0;
    logic [31:0] expSin  = '0;
    logic        expErr  = 1'b0;
    logic [31:0] pendCos = '0;
    logic [31:0] pendSin = '0;
    logic        pendErr = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            modelOn = 1'b1;
            rem     = 0;
            expCos  = '0;
            expSin  = '0;
            expErr  = 1'b0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 1) begin
                expCos = pendCos;
                expSin = pendSin;
                expErr = pendErr;
            end
        end else if (start) begin
            rotate(rad, pendCos, pendSin, pendErr);
            if (pendErr) begin
                rem    = 1;
                expCos = '0;
                expSin = '0;
                expErr = 1'b1;
            end else begin
                rem    = N_ITER + 1;
                expErr = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            check("ready", 32'(ready), 32'(rem == 0));
            check("done", 32'(done), 32'(rem == 1));
            check("cos_o", cos_o, expCos);
            check("sin_o", sin_o, expSin);
            check("err", 32'(err), 32'(expErr));
            if (done) doneCount++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic waitReady(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            tests++;
            fails++;
            $display("FAIL %s: ready timeout got 0 expected 1", name);
        end
    endtask

    task automatic doOp(input string name, input logic [31:0] r, input int expLat,
                        input logic [31:0] refCos, input logic [31:0] refSin, input logic refErr,
                        input bit chkC, input bit chkS, input logic [31:0] tol);
        int n;
        bit seen;
        waitReady(name);
        start = 1'b1;
        rad   = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        rad   = $urandom;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        check({name, " latency"}, 32'(n), 32'(expLat));
        if (seen) begin
            check({name, " err"}, 32'(err), 32'(refErr));
            if (chkC) near({name, " cos"}, cos_o, refCos, tol);
            if (chkS) near({name, " sin"}, sin_o, refSin, tol);
        end
    endtask

    function automatic logic [31:0] realRef(input logic [31:0] r, input bit wantSin);
        real a;
        a = $itor($signed(r)) / 1073741824.0;
        return wantSin ? $rtoi($sin(a) * 1073741824.0) : $rtoi($cos(a) * 1073741824.0);
    endfunction

    logic [31:0] extraVec [0:3] = '{32'h1000_0000, 32'hE000_0000, 32'h5A00_0000, 32'hC800_0000};

    initial begin
        int base;
        int lastDone;
        int pulses;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst ready", 32'(ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst cos", cos_o, 32'h0);
        check("rst sin", sin_o, 32'h0);

        doOp("zero", 32'h0000_0000, 9, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, TOL);
        doOp("pi4", 32'h3243_F6A8, 9, 32'h2D41_3CCD, 32'h2D41_3CCD, 1'b0, 1'b1, 1'b1, TOL);
        doOp("mpi2", 32'h9B78_12AF, 9, 32'h0, 32'hC000_0000, 1'b0, 1'b0, 1'b1, TOL);
        doOp("oor", 32'h7000_0000, 1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
        doOp("hpi", 32'h6487_ED51, 9, 32'h0, 32'h4000_0000, 1'b0, 1'b0, 1'b1, TOL);
        doOp("hpiPlus1", 32'h6487_ED52, 1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
        doOp("mhpiMinus1", 32'h9B78_12AE, 1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
        for (int k = 0; k < 4; k++)
            doOp("extra", extraVec[k], 9, realRef(extraVec[k], 1'b0), realRef(extraVec[k], 1'b1),
                 1'b0, 1'b1, 1'b1, TOL);

        // second start while iterating must be dropped
        waitReady("busyStart");
        start = 1'b1;
        rad   = 32'h2000_0000;
        @(posedge clk);
        #1 start = 1'b0;
        base = doneCount;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        rad   = 32'h7000_0000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check("busyStart dones", 32'(doneCount - base), 32'd1);

        // start held high: one result every N_ITER+2 cycles
        waitReady("held");
        start    = 1'b1;
        rad      = 32'h1800_0000;
        lastDone = -1;
        pulses   = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) begin
                if (lastDone >= 0) check("held period", 32'(cyc - lastDone), 32'd10);
                lastDone = cyc;
                pulses++;
            end
        end
        start = 1'b0;
        check("held pulses", 32'(pulses), 32'd4);

        // reset on the fourth iteration edge aborts the operation
        waitReady("midReset");
        start = 1'b1;
        rad   = 32'h3243_F6A8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midReset ready", 32'(ready), 32'd1);
        check("midReset done", 32'(done), 32'd0);
        check("midReset cos", cos_o, 32'h0);
        check("midReset sin", sin_o, 32'h0);
        doOp("afterReset", 32'h3243_F6A8, 9, 32'h2D41_3CCD, 32'h2D41_3CCD, 1'b0, 1'b1, 1'b1, TOL);

        // reset wins over a simultaneous start
        waitReady("rstStart");
        reset = 1'b1;
        start = 1'b1;
        rad   = 32'h0;
        @(posedge clk);
        #1 reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rstStart ready", 32'(ready), 32'd1);
        check("rstStart done", 32'(done), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
